// File: rtl/ysyx_23060059_exu_pkg.sv
// Shared execute-stage definitions: op codes, engine state encoding, MDU op classification.
package ysyx_23060059_exu_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] ALU_IMM   = 5'd0;
    localparam logic [OP_W-1:0] ALU_SRC   = 5'd1;
    localparam logic [OP_W-1:0] ALU_ADD   = 5'd2;
    localparam logic [OP_W-1:0] ALU_SUB   = 5'd3;
    localparam logic [OP_W-1:0] ALU_AND   = 5'd4;
    localparam logic [OP_W-1:0] ALU_OR    = 5'd5;
    localparam logic [OP_W-1:0] ALU_XOR   = 5'd6;
    localparam logic [OP_W-1:0] ALU_SL    = 5'd7;
    localparam logic [OP_W-1:0] ALU_SR    = 5'd8;
    localparam logic [OP_W-1:0] ALU_SSR   = 5'd9;
    localparam logic [OP_W-1:0] ALU_SLES  = 5'd10;
    localparam logic [OP_W-1:0] ALU_ULES  = 5'd11;
    localparam logic [OP_W-1:0] ALU_MUL   = 5'd12;
    localparam logic [OP_W-1:0] ALU_DIV   = 5'd13;
    localparam logic [OP_W-1:0] ALU_DIVU  = 5'd14;
    localparam logic [OP_W-1:0] ALU_REM   = 5'd15;
    localparam logic [OP_W-1:0] ALU_REMU  = 5'd16;
    localparam logic [OP_W-1:0] ALU_MULHU = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ALU  = 2'd1,
        ST_MDU  = 2'd2,
        ST_HOLD = 2'd3
    } exu_state_e;

    function automatic logic is_mdu_op(input logic [OP_W-1:0] op);
        return (op >= ALU_MUL) && (op <= ALU_MULHU);
    endfunction

endpackage

// File: rtl/ysyx_23060059_mdu.sv
// Iterative multiply/divide: shift-add multiplier and restoring divider, one bit per cycle.
// Divide-by-zero and signed overflow resolve in the first busy cycle.
module ysyx_23060059_mdu
    import ysyx_23060059_exu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic            busy, is_mul, sel_hi, neg_res, special;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] hi, lo, m, spec_res;

    logic            st_mul, st_signed, st_rem, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic            div_ge;
    logic [XLEN-1:0] hi_n, lo_n, raw;

    // Decode of the op being started
    assign st_mul    = (op == ALU_MUL) || (op == ALU_MULHU);
    assign st_signed = (op == ALU_DIV) || (op == ALU_REM);
    assign st_rem    = (op == ALU_REM) || (op == ALU_REMU);
    assign a_neg     = st_signed & a[XLEN-1];
    assign b_neg     = st_signed & b[XLEN-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // One iteration step: hi is accumulator/remainder, lo is multiplier/quotient
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
    assign div_shift = {hi, lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, m};
    assign div_ge    = ~div_diff[XLEN];
    assign hi_n      = is_mul ? mul_sum[XLEN:1] : (div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]);
    assign lo_n      = is_mul ? {mul_sum[0], lo[XLEN-1:1]} : {lo[XLEN-2:0], div_ge};
    assign raw       = sel_hi ? hi_n : lo_n;

    assign done   = busy & (special | (cnt == CW'(XLEN-1)));
    assign result = special ? spec_res : (neg_res ? -raw : raw);

    always_ff @(posedge clock) begin
        if (reset) begin
            busy     <= 1'b0;
            is_mul   <= 1'b0;
            sel_hi   <= 1'b0;
            neg_res  <= 1'b0;
            special  <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            m        <= '0;
            spec_res <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= '0;
            is_mul  <= st_mul;
            sel_hi  <= (op == ALU_MULHU) || st_rem;
            neg_res <= st_mul ? 1'b0 : (st_rem ? a_neg : (a_neg ^ b_neg));
            hi      <= '0;
            lo      <= st_mul ? b : a_mag;
            m       <= st_mul ? a : b_mag;
            if (!st_mul && (b == '0)) begin
                special  <= 1'b1;
                spec_res <= st_rem ? a : '1;
            end else if (st_signed && (a == XMIN) && (b == '1)) begin
                special  <= 1'b1;
                spec_res <= st_rem ? '0 : XMIN;
            end else begin
                special  <= 1'b0;
                spec_res <= '0;
            end
        end else if (busy) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ysyx_23060059_exu_mdu.sv
// Execute stage: input FIFO, single-cycle ALU and optional iterative MDU with a result register.
// Define YSYX_23060059_EXU_MDU_EN to build the MDU; otherwise MDU op codes return 0 on the ALU path.
module ysyx_23060059_exu_mdu
    import ysyx_23060059_exu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned PAYLOAD_W = 160
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_src1,
    input  logic [XLEN-1:0]      in_src2,
    input  logic [OP_W-1:0]      in_aluop,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic                 out_zero,
    output logic [XLEN-1:0]      out_src1,
    output logic [XLEN-1:0]      out_src2,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           state_o
);

    localparam int unsigned SHW   = $clog2(XLEN);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]      fifo_src1 [DEPTH];
    logic [XLEN-1:0]      fifo_src2 [DEPTH];
    logic [OP_W-1:0]      fifo_op   [DEPTH];
    logic [PAYLOAD_W-1:0] fifo_pl   [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    exu_state_e           state;

    logic                 full, empty, push, pop, head_mdu, alu_zero_c;
    logic [XLEN-1:0]      head_src1, head_src2, alu_res, mdu_result;
    logic [OP_W-1:0]      head_op;
    logic [PAYLOAD_W-1:0] head_pl;
    logic                 mdu_done;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = ~full;
    assign push      = in_valid & in_ready;
    assign pop       = (state == ST_IDLE) & ~empty;
    assign head_src1 = fifo_src1[rd_ptr];
    assign head_src2 = fifo_src2[rd_ptr];
    assign head_op   = fifo_op[rd_ptr];
    assign head_pl   = fifo_pl[rd_ptr];
    assign state_o   = state;

    // FIFO storage carries no reset; occupancy is tracked by count
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_src1[wr_ptr] <= in_src1;
            fifo_src2[wr_ptr] <= in_src2;
            fifo_op[wr_ptr]   <= in_aluop;
            fifo_pl[wr_ptr]   <= in_payload;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Single-cycle ALU on the FIFO head
    always_comb begin
        alu_res = '0;
        case (head_op)
            ALU_IMM:  alu_res = head_src2;
            ALU_SRC:  alu_res = head_src1;
            ALU_ADD:  alu_res = head_src1 + head_src2;
            ALU_SUB:  alu_res = head_src1 - head_src2;
            ALU_AND:  alu_res = head_src1 & head_src2;
            ALU_OR:   alu_res = head_src1 | head_src2;
            ALU_XOR:  alu_res = head_src1 ^ head_src2;
            ALU_SL:   alu_res = head_src1 << head_src2[SHW-1:0];
            ALU_SR:   alu_res = head_src1 >> head_src2[SHW-1:0];
            ALU_SSR:  alu_res = XLEN'($signed(head_src1) >>> head_src2[SHW-1:0]);
            ALU_SLES: alu_res = {{(XLEN-1){1'b0}}, $signed(head_src1) < $signed(head_src2)};
            ALU_ULES: alu_res = {{(XLEN-1){1'b0}}, head_src1 < head_src2};
            default:  alu_res = '0;
        endcase
    end

    assign alu_zero_c = ((head_op == ALU_ADD) || (head_op == ALU_SUB)) && (alu_res == '0);

`ifdef YSYX_23060059_EXU_MDU_EN
    assign head_mdu = is_mdu_op(head_op);

    ysyx_23060059_mdu #(
        .XLEN(XLEN)
    ) u_mdu (
        .clock  (clock),
        .reset  (reset),
        .start  (pop & head_mdu),
        .op     (head_op),
        .a      (head_src1),
        .b      (head_src2),
        .done   (mdu_done),
        .result (mdu_result)
    );
`else
    assign head_mdu   = 1'b0;
    assign mdu_done   = 1'b0;
    assign mdu_result = '0;
`endif

    // Engine: ALU and HOLD both present a valid result until the LSU takes it
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_src1    <= '0;
            out_src2    <= '0;
            out_payload <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        out_src1    <= head_src1;
                        out_src2    <= head_src2;
                        out_payload <= head_pl;
                        if (head_mdu) begin
                            state <= ST_MDU;
                        end else begin
                            out_result <= alu_res;
                            out_zero   <= alu_zero_c;
                            out_valid  <= 1'b1;
                            state      <= ST_ALU;
                        end
                    end
                end
                ST_MDU: begin
                    if (mdu_done) begin
                        out_result <= mdu_result;
                        out_zero   <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= ST_HOLD;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        state <= ST_HOLD;
                    end
                end
            endcase
        end
    end

endmodule
